// File: rtl/motion_pkg.sv
// Shared types for player_motion: per-channel vertical state and the default widths.
package motion_pkg;

  localparam int POS_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    GROUND,
    RISE,
    FALL
  } motion_state_t;

  typedef logic signed [POS_W_DEFAULT:0] vel_t;

endpackage

// File: rtl/player_motion_ch.sv
// One player channel: clamped walking, facing, and the jump/gravity state machine.
// Defining PLAYER_MOTION_DOUBLE_JUMP_EN allows one extra jump per flight.
module player_motion_ch
  import motion_pkg::*;
#(
  parameter int POS_W     = POS_W_DEFAULT,
  parameter int X_START   = 64,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 960,
  parameter int Y_MIN     = 0,
  parameter int GROUND_Y  = 700,
  parameter int STEP_X    = 4,
  parameter int JUMP_V    = 12,
  parameter int GRAVITY   = 1,
  parameter int VMAX_FALL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_frame_tick,
  input  logic             i_left,
  input  logic             i_right,
  input  logic             i_jump,
  output logic [POS_W-1:0] o_xpos,
  output logic [POS_W-1:0] o_ypos,
  output logic             o_facing,
  output logic             o_airborne
);

  // One extra bit keeps every sum signed, so moving past an edge clamps instead of wrapping.
  typedef logic signed [POS_W:0] svel_t;

  localparam svel_t L_X_START   = svel_t'(X_START);
  localparam svel_t L_X_MIN     = svel_t'(X_MIN);
  localparam svel_t L_X_MAX     = svel_t'(X_MAX);
  localparam svel_t L_Y_MIN     = svel_t'(Y_MIN);
  localparam svel_t L_GROUND_Y  = svel_t'(GROUND_Y);
  localparam svel_t L_STEP_X    = svel_t'(STEP_X);
  localparam svel_t L_JUMP_V    = svel_t'(JUMP_V);
  localparam svel_t L_GRAVITY   = svel_t'(GRAVITY);
  localparam svel_t L_VMAX_FALL = svel_t'(VMAX_FALL);

  motion_state_t    r_state, w_stateNext;
  logic [POS_W-1:0] r_x, r_y, w_xNext, w_yNext;
  svel_t            r_vy, w_vyNext, w_xSum, w_ySum, w_vyInc;
  logic             r_jumpPrev, r_facing, r_airborne;
  logic             w_facingNext, w_airborneNext, w_jumpEdge;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
  logic             r_airJumpUsed, w_airJumpUsedNext;
`endif

  always_comb begin
    w_xNext        = r_x;
    w_yNext        = r_y;
    w_vyNext       = r_vy;
    w_stateNext    = r_state;
    w_facingNext   = r_facing;
    w_airborneNext = r_airborne;
    w_jumpEdge     = i_jump & ~r_jumpPrev;
    w_xSum         = svel_t'({1'b0, r_x});
    w_ySum         = svel_t'({1'b0, r_y}) + r_vy;
    w_vyInc        = r_vy + L_GRAVITY;

    if (i_left && !i_right) begin
      w_xSum       = svel_t'({1'b0, r_x}) - L_STEP_X;
      w_xNext      = (w_xSum < L_X_MIN) ? L_X_MIN[POS_W-1:0] : w_xSum[POS_W-1:0];
      w_facingNext = 1'b1;
    end else if (i_right && !i_left) begin
      w_xSum       = svel_t'({1'b0, r_x}) + L_STEP_X;
      w_xNext      = (w_xSum > L_X_MAX) ? L_X_MAX[POS_W-1:0] : w_xSum[POS_W-1:0];
      w_facingNext = 1'b0;
    end

    case (r_state)
      GROUND: begin
        if (w_jumpEdge) begin
          w_vyNext       = -L_JUMP_V;
          w_stateNext    = RISE;
          w_airborneNext = 1'b1;
        end
      end
      RISE: begin
        if (w_ySum <= L_Y_MIN) begin
          w_yNext     = L_Y_MIN[POS_W-1:0];
          w_vyNext    = '0;
          w_stateNext = FALL;
        end else begin
          w_yNext  = w_ySum[POS_W-1:0];
          w_vyNext = w_vyInc;
          if (w_vyInc >= 0) w_stateNext = FALL;
        end
      end
      FALL: begin
        if (w_ySum >= L_GROUND_Y) begin
          w_yNext        = L_GROUND_Y[POS_W-1:0];
          w_vyNext       = '0;
          w_stateNext    = GROUND;
          w_airborneNext = 1'b0;
        end else begin
          w_yNext  = w_ySum[POS_W-1:0];
          w_vyNext = (w_vyInc > L_VMAX_FALL) ? L_VMAX_FALL : w_vyInc;
        end
      end
      default: ;
    endcase

`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
    // The air jump overrides this frame's vertical step, mirroring a jump from the ground.
    w_airJumpUsedNext = r_airJumpUsed;
    if ((r_state != GROUND) && w_jumpEdge && !r_airJumpUsed) begin
      w_yNext           = r_y;
      w_vyNext          = -L_JUMP_V;
      w_stateNext       = RISE;
      w_airborneNext    = 1'b1;
      w_airJumpUsedNext = 1'b1;
    end else if (w_stateNext == GROUND) begin
      w_airJumpUsedNext = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= GROUND;
      r_x        <= L_X_START[POS_W-1:0];
      r_y        <= L_GROUND_Y[POS_W-1:0];
      r_vy       <= '0;
      r_jumpPrev <= 1'b0;
      r_facing   <= 1'b0;
      r_airborne <= 1'b0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
      r_airJumpUsed <= 1'b0;
`endif
    end else if (i_frame_tick) begin
      r_state    <= w_stateNext;
      r_x        <= w_xNext;
      r_y        <= w_yNext;
      r_vy       <= w_vyNext;
      r_jumpPrev <= i_jump;
      r_facing   <= w_facingNext;
      r_airborne <= w_airborneNext;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
      r_airJumpUsed <= w_airJumpUsedNext;
`endif
    end
  end

  assign o_xpos     = r_x;
  assign o_ypos     = r_y;
  assign o_facing   = r_facing;
  assign o_airborne = r_airborne;

endmodule

// File: rtl/player_motion.sv
// N_PLAYERS independent motion channels, each started X_SPACING further right.
// PLAYER_MOTION_DOUBLE_JUMP_EN is forwarded to every channel.
module player_motion
  import motion_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int POS_W     = POS_W_DEFAULT,
  parameter int X_START   = 64,
  parameter int X_SPACING = 128,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 960,
  parameter int Y_MIN     = 0,
  parameter int GROUND_Y  = 700,
  parameter int STEP_X    = 4,
  parameter int JUMP_V    = 12,
  parameter int GRAVITY   = 1,
  parameter int VMAX_FALL = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_tick,
  input  logic [N_PLAYERS-1:0]             left,
  input  logic [N_PLAYERS-1:0]             right,
  input  logic [N_PLAYERS-1:0]             jump,
  output logic [N_PLAYERS-1:0][POS_W-1:0] xpos,
  output logic [N_PLAYERS-1:0][POS_W-1:0] ypos,
  output logic [N_PLAYERS-1:0]             facing,
  output logic [N_PLAYERS-1:0]             airborne
);

  for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_ch
    player_motion_ch #(
      .POS_W    (POS_W),
      .X_START  (X_START + gi * X_SPACING),
      .X_MIN    (X_MIN),
      .X_MAX    (X_MAX),
      .Y_MIN    (Y_MIN),
      .GROUND_Y (GROUND_Y),
      .STEP_X   (STEP_X),
      .JUMP_V   (JUMP_V),
      .GRAVITY  (GRAVITY),
      .VMAX_FALL(VMAX_FALL)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_frame_tick(frame_tick),
      .i_left      (left[gi]),
      .i_right     (right[gi]),
      .i_jump      (jump[gi]),
      .o_xpos      (xpos[gi]),
      .o_ypos      (ypos[gi]),
      .o_facing    (facing[gi]),
      .o_airborne  (airborne[gi])
    );
  end

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: default instance plus a low-ceiling and a high-jump variant.
// Expectations for the second airborne jump depend on PLAYER_MOTION_DOUBLE_JUMP_EN.
module tb_player_motion;

  typedef enum int {S_X0, S_X1, S_Y0, S_Y1, S_F0, S_F1, S_A0, S_A1,
                    S_XC, S_YC, S_FC, S_AC, S_XF, S_YF, S_FF, S_AF} sel_t;

  typedef struct {
    int    tick;
    sel_t  sel;
    int    value;
    string name;
  } expEntry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, frame_tick;
  logic [1:0]        left, right, jump;
  logic              jumpC, jumpF;
  logic [1:0][11:0]  xpos, ypos;
  logic [1:0]        facing, airborne;
  logic [0:0][11:0]  xposC, yposC, xposF, yposF;
  logic [0:0]        facingC, airborneC, facingF, airborneF;

  expEntry_t scoreQ[$];
  int driverTick = 0;
  int monTick    = 0;
  int checkCount = 0;
  int errCount   = 0;

  player_motion dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .left(left), .right(right), .jump(jump),
    .xpos(xpos), .ypos(ypos), .facing(facing), .airborne(airborne)
  );

  player_motion #(.N_PLAYERS(1), .Y_MIN(680)) dutCeil (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .left(1'b0), .right(1'b0), .jump(jumpC),
    .xpos(xposC), .ypos(yposC), .facing(facingC), .airborne(airborneC)
  );

  player_motion #(.N_PLAYERS(1), .GROUND_Y(1000), .JUMP_V(30)) dutFast (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .left(1'b0), .right(1'b0), .jump(jumpF),
    .xpos(xposF), .ypos(yposF), .facing(facingF), .airborne(airborneF)
  );

  function automatic int getActual(sel_t sel);
    case (sel)
      S_X0: return int'(xpos[0]);
      S_X1: return int'(xpos[1]);
      S_Y0: return int'(ypos[0]);
      S_Y1: return int'(ypos[1]);
      S_F0: return int'(facing[0]);
      S_F1: return int'(facing[1]);
      S_A0: return int'(airborne[0]);
      S_A1: return int'(airborne[1]);
      S_XC: return int'(xposC[0]);
      S_YC: return int'(yposC[0]);
      S_FC: return int'(facingC[0]);
      S_AC: return int'(airborneC[0]);
      S_XF: return int'(xposF[0]);
      S_YF: return int'(yposF[0]);
      S_FF: return int'(facingF[0]);
      S_AF: return int'(airborneF[0]);
      default: return -1;
    endcase
  endfunction

  function automatic void pushExp(string name, sel_t sel, int value);
    expEntry_t e;
    e.tick  = driverTick;
    e.sel   = sel;
    e.value = value;
    e.name  = name;
    scoreQ.push_back(e);
  endfunction

  task automatic checkOutput(input expEntry_t e);
    int actual;
    actual = getActual(e.sel);
    checkCount++;
    if (actual != e.value) begin
      errCount++;
      $display("[TB] FAIL %s (tick %0d): got %0d, expected %0d", e.name, e.tick, actual, e.value);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] l, input logic [1:0] r, input logic [1:0] j,
                               input logic jc, input logic jf);
    @(negedge clk);
    rst        = 1'b1;
    left       = l;
    right      = r;
    jump       = j;
    jumpC      = jc;
    jumpF      = jf;
    frame_tick = 1'b1;
    driverTick++;
  endtask

  // Three cycles of reset; frame_tick is high on the last one to show reset wins.
  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0;
    left = '0; right = '0; jump = '0; jumpC = 1'b0; jumpF = 1'b0;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b1;
    driverTick++;
  endtask

  // Monitor: a frame tick seen at a rising edge means outputs are valid on the next falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (frame_tick === 1'b1) begin
        monTick++;
        @(negedge clk);
        while (scoreQ.size() > 0 && scoreQ[0].tick == monTick) begin
          checkOutput(scoreQ.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b0; frame_tick = 1'b0;
    left = '0; right = '0; jump = '0; jumpC = 1'b0; jumpF = 1'b0;

    applyReset();
    pushExp("rst_x0", S_X0, 64);   pushExp("rst_x1", S_X1, 192);
    pushExp("rst_y0", S_Y0, 700);  pushExp("rst_y1", S_Y1, 700);
    pushExp("rst_f0", S_F0, 0);    pushExp("rst_f1", S_F1, 0);
    pushExp("rst_a0", S_A0, 0);    pushExp("rst_a1", S_A1, 0);
    pushExp("rst_xc", S_XC, 64);   pushExp("rst_yc", S_YC, 700);
    pushExp("rst_fc", S_FC, 0);    pushExp("rst_ac", S_AC, 0);
    pushExp("rst_xf", S_XF, 64);   pushExp("rst_yf", S_YF, 1000);
    pushExp("rst_ff", S_FF, 0);    pushExp("rst_af", S_AF, 0);

    // Short walk, one step back, then both keys held.
    for (int t = 1; t <= 5; t++) applyStimulus(2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    pushExp("walk5_x0", S_X0, 84);
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    pushExp("back_x0", S_X0, 80);  pushExp("back_f0", S_F0, 1);
    for (int t = 1; t <= 10; t++) applyStimulus(2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
    pushExp("both_x0", S_X0, 80);  pushExp("both_f0", S_F0, 1);
    pushExp("both_x1", S_X1, 192); pushExp("both_f1", S_F1, 0);

    for (int t = 1; t <= 300; t++) begin
      applyStimulus(2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
      if (t == 1)   begin pushExp("right1_x0", S_X0, 84); pushExp("right1_f0", S_F0, 0); end
      if (t == 220) pushExp("right220_x0", S_X0, 960);
      if (t == 300) begin pushExp("rclamp_x0", S_X0, 960); pushExp("rclamp_x1", S_X1, 192); end
    end
    for (int t = 1; t <= 300; t++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
      if (t == 1)   begin pushExp("left1_x0", S_X0, 956); pushExp("left1_f0", S_F0, 1); end
      if (t == 300) begin pushExp("lclamp_x0", S_X0, 0); pushExp("lclamp_f0", S_F0, 1); end
    end

    // Held jump on ch1, ceiling and high-jump variants.
    for (int t = 1; t <= 60; t++) begin
      applyStimulus(2'b00, 2'b00, (t <= 40) ? 2'b10 : 2'b00, (t <= 40), 1'b1);
      if (t == 1)  begin pushExp("jmp1_y1", S_Y1, 700); pushExp("jmp1_a1", S_A1, 1);
                         pushExp("jmp1_af", S_AF, 1); end
      if (t == 2)  pushExp("jmp2_y1", S_Y1, 688);
      if (t == 13) begin pushExp("apex_y1", S_Y1, 622); pushExp("apex_a1", S_A1, 1);
                         pushExp("apex_y0", S_Y0, 700); pushExp("apex_x0", S_X0, 0);
                         pushExp("apex_a0", S_A0, 0); end
      if (t == 14) pushExp("fall14_y1", S_Y1, 622);
      if (t == 25) pushExp("fall25_y1", S_Y1, 688);
      if (t == 26) begin pushExp("land_y1", S_Y1, 700); pushExp("land_a1", S_A1, 0); end
      if (t == 40) begin pushExp("held_y1", S_Y1, 700); pushExp("held_a1", S_A1, 0); end
      if (t == 2)  pushExp("ceil2_yc", S_YC, 688);
      if (t == 3)  pushExp("ceil3_yc", S_YC, 680);
      if (t == 4)  pushExp("ceil4_yc", S_YC, 680);
      if (t == 5)  pushExp("ceil5_yc", S_YC, 681);
      if (t == 9)  pushExp("ceil9_yc", S_YC, 695);
      if (t == 10) begin pushExp("ceil10_yc", S_YC, 700); pushExp("ceil10_ac", S_AC, 0); end
      if (t == 20) pushExp("ceil20_ac", S_AC, 0);
      if (t == 31) pushExp("fast31_yf", S_YF, 535);
      if (t == 47) pushExp("fast47_yf", S_YF, 655);
      if (t == 49) pushExp("fast49_yf", S_YF, 687);
      if (t == 50) pushExp("fast50_yf", S_YF, 703);
    end

    // Reset in mid-flight.
    for (int t = 1; t <= 3; t++) applyStimulus(2'b00, 2'b01, 2'b10, 1'b0, 1'b0);
    pushExp("mid_y1", S_Y1, 677);
    applyReset();
    pushExp("midrst_y1", S_Y1, 700); pushExp("midrst_a1", S_A1, 0);
    pushExp("midrst_x0", S_X0, 64);  pushExp("midrst_yf", S_YF, 1000);

    // Jump edges at ticks 1, 10, 12 and 42.
    for (int t = 1; t <= 43; t++) begin
      applyStimulus(2'b00, 2'b00,
                    ((t <= 8) || t == 10 || t == 12 || t == 42) ? 2'b10 : 2'b00, 1'b0, 1'b0);
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
      if (t == 10) begin pushExp("dj10_y1", S_Y1, 632); pushExp("dj10_a1", S_A1, 1); end
      if (t == 11) pushExp("dj11_y1", S_Y1, 620);
      if (t == 13) pushExp("dj13_y1", S_Y1, 599);
      if (t == 22) pushExp("dj22_y1", S_Y1, 554);
      if (t == 26) begin pushExp("dj26_y1", S_Y1, 560); pushExp("dj26_a1", S_A1, 1); end
      if (t == 39) pushExp("dj39_y1", S_Y1, 690);
      if (t == 40) begin pushExp("dj40_y1", S_Y1, 700); pushExp("dj40_a1", S_A1, 0); end
`else
      if (t == 10) begin pushExp("dj10_y1", S_Y1, 628); pushExp("dj10_a1", S_A1, 1); end
      if (t == 13) pushExp("dj13_y1", S_Y1, 622);
      if (t == 26) begin pushExp("dj26_y1", S_Y1, 700); pushExp("dj26_a1", S_A1, 0); end
      if (t == 40) pushExp("dj40_a1", S_A1, 0);
`endif
      if (t == 42) begin pushExp("fresh42_y1", S_Y1, 700); pushExp("fresh42_a1", S_A1, 1); end
      if (t == 43) pushExp("fresh43_y1", S_Y1, 688);
    end

    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 20 && scoreQ.size() > 0; i++) @(negedge clk);
    while (scoreQ.size() > 0) begin
      expEntry_t e;
      e = scoreQ.pop_front();
      checkCount++;
      errCount++;
      $display("[TB] FAIL %s (tick %0d): never observed, expected %0d", e.name, e.tick, e.value);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Multi-channel successor to the single-player movement block.
- Keeps independent horizontal position, jump physics and facing for N_PLAYERS sprites.
- Advances once per frame on `frame_tick`, with gravity, jump-edge detection, ceiling/ground/wall clamping and a facing output.
- Sits between the key decoder(s) and the sprite draw stages; all outputs are registered.

Parameters:
- N_PLAYERS, 2, number of independent channels (1..4)
- POS_W, 12, width of position outputs
- X_START, 64, reset X of channel 0
- X_SPACING, 128, reset X offset between channels (channel i starts at X_START + i*X_SPACING)
- X_MIN, 0, leftmost allowed X
- X_MAX, 960, rightmost allowed X (screen width minus sprite width)
- Y_MIN, 0, ceiling Y
- GROUND_Y, 700, floor Y (screen Y grows downward)
- STEP_X, 4, horizontal pixels per frame
- JUMP_V, 12, initial upward speed, pixels/frame
- GRAVITY, 1, speed increment per frame
- VMAX_FALL, 16, downward speed saturation

Ports:
- clk  in  1  system clock (65 MHz)
- rst  in  1  synchronous reset, active-low
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- left  in  N_PLAYERS  per-channel move-left level
- right  in  N_PLAYERS  per-channel move-right level
- jump  in  N_PLAYERS  per-channel jump level
- xpos  out  N_PLAYERS x POS_W  per-channel X
- ypos  out  N_PLAYERS x POS_W  per-channel Y
- facing  out  N_PLAYERS  1 = facing left (sprite mirrored)
- airborne  out  N_PLAYERS  1 while not on ground

Behaviour:
- One clock `clk`. Reset is synchronous and active-low: `rst` = 0 sampled on a `clk` edge resets; `rst` is the port name.
- Reset values:
  - xpos[i] = X_START + i*X_SPACING
  - ypos[i] = GROUND_Y
  - facing = 0, airborne = 0
  - velocity vy = 0, state GROUND, jump_prev = 0
- Reset mid-flight returns every channel to these values on that edge.
- Update timing:
  - State changes only on a cycle where frame_tick = 1.
  - New outputs are visible the following cycle (latency 1).
  - Inputs are sampled only on that cycle.
- Horizontal, per frame:
  - left & !right: x = max(x - STEP_X, X_MIN), facing = 1.
  - right & !left: x = min(x + STEP_X, X_MAX), facing = 0.
  - Both or neither: x and facing unchanged.
  - Compute in POS_W+1 bits signed so underflow clamps, never wraps.
- Jump edge: jump_edge = jump & !jump_prev, where jump_prev is the jump level at the previous frame_tick. Holding jump yields one edge only.
- State machine per channel, with vy signed POS_W+1 bits:
  - GROUND, jump_edge: vy = -JUMP_V, y unchanged, go to RISE, airborne = 1.
  - RISE: y_n = y + vy.
    - If y_n <= Y_MIN: y = Y_MIN, vy = 0, go to FALL.
    - Else: y = y_n, vy += GRAVITY; go to FALL when the new vy >= 0.
  - FALL: y_n = y + vy.
    - If y_n >= GROUND_Y: y = GROUND_Y, vy = 0, go to GROUND, airborne = 0.
    - Else: y = y_n, vy = min(vy + GRAVITY, VMAX_FALL).
  - jump_edge while in RISE/FALL is ignored (see optional feature).
- Horizontal and vertical updates in the same frame are independent.
- Channels never interact.

Optional Feature:
- Macro: PLAYER_MOTION_DOUBLE_JUMP_EN.
- Defined:
  - Each channel gets a 1-bit air_jump_used flag, cleared on reset and on landing.
  - jump_edge in RISE or FALL with the flag clear sets vy = -JUMP_V, state RISE and sets the flag.
  - A further airborne edge is ignored.
- Undefined: the flag is absent and airborne jump edges are always ignored.

Decomposition:
- Package motion_pkg:
  - `motion_state_t` enum {GROUND, RISE, FALL}
  - `POS_W` default
  - signed velocity typedef `vel_t` (POS_W+1 bits)
- Sub-module player_motion_ch: one channel holding state, x, y, vy, jump_prev and facing.
- player_motion generates N_PLAYERS instances, offsetting X_START per index.

Test Plan:
- Reset: hold rst = 0 for 3 cycles -> xpos = {64, 192}, ypos = {700, 700}, facing = 0, airborne = 0.
- Walk and clamp: ch0 right = 1 for 300 ticks -> xpos[0] = 960 (X_MAX), facing[0] = 0. Then left = 1 for 300 ticks -> xpos[0] = 0, facing[0] = 1. Never wraps.
- Conflicting inputs: left = right = 1 for 10 ticks -> xpos and facing unchanged.
- Jump trajectory: ch1 jump pulse at tick 1 (held 40 ticks) ->
  - tick 1: ypos = 700, airborne = 1, vy = -12.
  - tick 13: ypos = 622 (apex), FALL.
  - tick 26: ypos = 700, airborne = 0.
  - Held jump gives no second jump.
  - ch0 is unaffected throughout.
- Ceiling/terminal speed: GROUND_Y = 700, Y_MIN = 680, jump -> ypos clamps to 680 then falls. With JUMP_V = 0 from a raised start, vy saturates at 16.
- Macro on: second jump edge at tick 10 -> vy reset to -12. A third edge is ignored. After landing a fresh jump works. Same stimulus with the macro off -> second edge ignored, landing at tick 26.
